drone_flight_sequencer: RTL and testbench
=========================================

DRONE_FLIGHT_SEQUENCER -- requirements
Module: drone_flight_sequencer

Parameters
REQ-001 ARM_TICKS, 4, number of tick strobes spent in ARMING before spin-up.
REQ-002 STEP, 16, duty increment/decrement per tick during SPINUP/DESCEND.
REQ-003 MIN_DUTY, 32, idle-spin duty on entering SPINUP and lower clamp in FLIGHT.
REQ-004 HOVER_DUTY, 128, SPINUP target duty.
REQ-005 MAX_DUTY, 240, upper clamp in FLIGHT.

Interface
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 tick  in  1  one-cycle timebase strobe; all ramps and counts advance only on cycles with tick=1.
REQ-009 gyrocheck  in  1  gyro healthy; 0 = sensor fault.
REQ-010 reciverenable  in  1  radio link present.
REQ-011 land_req  in  1  level, pilot landing request.
REQ-012 fault_clr  in  1  one-cycle fault acknowledge.
REQ-013 throttle_cmd  in  8  pilot duty request, used in FLIGHT only.
REQ-014 motor_duty  out  8  registered motor PWM duty command.
REQ-015 state  out  3  encoded state: IDLE=0, ARMING=1, SPINUP=2, FLIGHT=3, DESCEND=4, FAULT=5.
REQ-016 armed  out  1  high in ARMING, SPINUP, FLIGHT and DESCEND.
REQ-017 takeoff  out  1  high in SPINUP and FLIGHT.
REQ-018 landing  out  1  high in IDLE and DESCEND.
REQ-019 fault  out  1  high in FAULT.

Function
REQ-020 All outputs shall be decoded from registered state or driven from registers, with no input-to-output combinational path.
REQ-021 Transition priority in every armed state shall be: gyrocheck=0 -> FAULT; else reciverenable=0 or land_req=1 -> DESCEND (from ARMING -> IDLE); else normal flow.
REQ-022 IDLE: motor_duty=0, arm counter=0; reciverenable=1 and gyrocheck=1 in the same cycle -> ARMING next cycle.
REQ-023 ARMING: motor_duty=0; counter increments on each tick; on the tick at which counter reaches ARM_TICKS -> SPINUP with motor_duty=MIN_DUTY; loss of either input -> IDLE with counter cleared.
REQ-024 SPINUP: on each tick, motor_duty=min(motor_duty+STEP, HOVER_DUTY), computed 9-bit with no 8-bit wrap; the cycle motor_duty equals HOVER_DUTY -> FLIGHT.
REQ-025 FLIGHT: every cycle, motor_duty<=clamp(throttle_cmd, MIN_DUTY, MAX_DUTY), 1-cycle latency.
REQ-026 DESCEND: on each tick, motor_duty=max(motor_duty-STEP, 0), with no underflow wrap; when motor_duty is 0 -> IDLE; reciverenable regained or land_req deasserted does not abort the descent.
REQ-027 FAULT: motor_duty=0 on entry cycle; exit to IDLE only when fault_clr=1 and reciverenable=0 in the same cycle; otherwise hold.
REQ-028 tick coincident with a priority transition: the transition wins, and no ramp step is applied that cycle.
REQ-029 Unused state encodings (6, 7) -> FAULT next cycle.

Reset
REQ-030 reset=0 shall immediately force state=IDLE, motor_duty=0, arm counter=0, landing=1, and all other flags=0, regardless of clk, including mid-flight.
REQ-031 Outputs shall remain at reset values until the first rising clk edge after reset returns to 1.

Verification
REQ-032 Reset, then gyrocheck=1, reciverenable=1, 4 ticks -> ARMING, SPINUP; duty 32,48,...,128 over 6 ticks -> FLIGHT.
REQ-033 FLIGHT with throttle_cmd=10, then 250, then 100 -> motor_duty 32, 240, 100, each one cycle later.
REQ-034 FLIGHT at duty 40, land_req=1 -> DESCEND; duty 24, 8, 0 on successive ticks -> IDLE.
REQ-035 ARMING after 2 ticks, reciverenable=0 -> IDLE; re-arm requires a full 4 ticks.
REQ-036 SPINUP, gyrocheck=0 with tick and reciverenable=0 in the same cycle -> FAULT, duty 0; fault_clr while reciverenable=1 -> stays FAULT; fault_clr with reciverenable=0 -> IDLE.
REQ-037 FLIGHT at duty 200, assert reset=0 asynchronously between edges -> duty=0, state=IDLE before the next clk edge.

Source files
------------

// File: rtl/drone_flight_sequencer.sv
// Drone flight sequencer: arms, spins up, flies, descends and latches faults.
// Motor duty and state are registered; status flags decode from the registered state.
module drone_flight_sequencer #(
  parameter int ARM_TICKS  = 4,
  parameter int STEP       = 16,
  parameter int MIN_DUTY   = 32,
  parameter int HOVER_DUTY = 128,
  parameter int MAX_DUTY   = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       gyrocheck,
  input  logic       reciverenable,
  input  logic       land_req,
  input  logic       fault_clr,
  input  logic [7:0] throttle_cmd,
  output logic [7:0] motor_duty,
  output logic [2:0] state,
  output logic       armed,
  output logic       takeoff,
  output logic       landing,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMING  = 3'd1,
    S_SPINUP  = 3'd2,
    S_FLIGHT  = 3'd3,
    S_DESCEND = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  localparam int CW = $clog2(ARM_TICKS + 1);
  localparam logic [CW-1:0] ARM_LAST = CW'(ARM_TICKS - 1);
  localparam logic [7:0] MIN_D   = 8'(MIN_DUTY);
  localparam logic [7:0] MAX_D   = 8'(MAX_DUTY);
  localparam logic [7:0] HOVER_D = 8'(HOVER_DUTY);
  localparam logic [8:0] HOVER_9 = 9'(HOVER_DUTY);
  localparam logic [8:0] STEP_9  = 9'(STEP);

  state_e        state_q, state_d;
  logic [7:0]    duty_q, duty_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    up_sum_s;
  logic [8:0]    down_diff_s;
  logic [7:0]    thr_clamp_s;
  logic          abort_s;

  // Ramp arithmetic is 9-bit so a step can never wrap the 8-bit duty.
  assign up_sum_s    = {1'b0, duty_q} + STEP_9;
  assign down_diff_s = {1'b0, duty_q} - STEP_9;
  assign abort_s     = !reciverenable || land_req;

  // Pilot throttle limited to the flight window.
  always_comb begin
    thr_clamp_s = throttle_cmd;
    if (throttle_cmd < MIN_D) begin
      thr_clamp_s = MIN_D;
    end else if (throttle_cmd > MAX_D) begin
      thr_clamp_s = MAX_D;
    end else begin
      thr_clamp_s = throttle_cmd;
    end
  end

  // Next state, duty and arm count; safety transitions pre-empt any ramp step.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        duty_d = 8'd0;
        cnt_d  = '0;
        if (reciverenable && gyrocheck) begin
          state_d = S_ARMING;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMING: begin
        duty_d = 8'd0;
        if (!gyrocheck) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (abort_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == ARM_LAST) begin
            state_d = S_SPINUP;
            duty_d  = MIN_D;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_SPINUP: begin
        if (!gyrocheck) begin
          state_d = S_FAULT;
          duty_d  = 8'd0;
        end else if (abort_s) begin
          state_d = S_DESCEND;
        end else if (duty_q == HOVER_D) begin
          state_d = S_FLIGHT;
        end else if (tick) begin
          duty_d = (up_sum_s >= HOVER_9) ? HOVER_D : up_sum_s[7:0];
        end else begin
          duty_d = duty_q;
        end
      end
      S_FLIGHT: begin
        if (!gyrocheck) begin
          state_d = S_FAULT;
          duty_d  = 8'd0;
        end else if (abort_s) begin
          state_d = S_DESCEND;
        end else begin
          duty_d = thr_clamp_s;
        end
      end
      S_DESCEND: begin
        // Regaining the link or dropping land_req does not cancel a descent.
        if (!gyrocheck) begin
          state_d = S_FAULT;
          duty_d  = 8'd0;
        end else if (duty_q == 8'd0) begin
          state_d = S_IDLE;
        end else if (tick) begin
          duty_d = down_diff_s[8] ? 8'd0 : down_diff_s[7:0];
        end else begin
          duty_d = duty_q;
        end
      end
      S_FAULT: begin
        duty_d = 8'd0;
        cnt_d  = '0;
        if (fault_clr && !reciverenable) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_FAULT;
        duty_d  = 8'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, duty and arm count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      duty_q  <= 8'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
    end
  end

  assign motor_duty = duty_q;
  assign state      = state_q;
  assign armed      = (state_q == S_ARMING) || (state_q == S_SPINUP) ||
                      (state_q == S_FLIGHT) || (state_q == S_DESCEND);
  assign takeoff    = (state_q == S_SPINUP) || (state_q == S_FLIGHT);
  assign landing    = (state_q == S_IDLE) || (state_q == S_DESCEND);
  assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_drone_flight_sequencer.sv
// Scoreboard bench for drone_flight_sequencer: directed scenarios then random traffic,
// each cycle checked against a behavioural model of the flight rules.
module tb_drone_flight_sequencer;

  localparam int ARM_TICKS = 4, STEP = 16, MIN_D = 32, HOVER = 128, MAX_D = 240;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, gyrocheck = 1'b0, reciverenable = 1'b0;
  logic       land_req = 1'b0, fault_clr = 1'b0;
  logic [7:0] throttle_cmd = 8'd0;
  logic [7:0] motor_duty;
  logic [2:0] state;
  logic       armed, takeoff, landing, fault;

  drone_flight_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .gyrocheck(gyrocheck),
    .reciverenable(reciverenable), .land_req(land_req), .fault_clr(fault_clr),
    .throttle_cmd(throttle_cmd), .motor_duty(motor_duty), .state(state),
    .armed(armed), .takeoff(takeoff), .landing(landing), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] duty;
    logic       arm, tko, lnd, flt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   m_st = 0, m_duty = 0, m_cnt = 0;

  function automatic exp_t mk(input int st, input int duty);
    exp_t e;
    e.st   = 3'(st);
    e.duty = 8'(duty);
    e.arm  = (st >= 1) && (st <= 4);
    e.tko  = (st == 2) || (st == 3);
    e.lnd  = (st == 0) || (st == 4);
    e.flt  = (st == 5);
    return e;
  endfunction

  task automatic compare(input string name, input exp_t e);
    exp_t a;
    a = '{st: state, duty: motor_duty, arm: armed, tko: takeoff, lnd: landing, flt: fault};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t: got st=%0d duty=%0d a/t/l/f=%b%b%b%b, expected st=%0d duty=%0d a/t/l/f=%b%b%b%b",
               name, $time, a.st, a.duty, a.arm, a.tko, a.lnd, a.flt,
               e.st, e.duty, e.arm, e.tko, e.lnd, e.flt);
    end
  endtask

  // Reference model: states 0..5 = IDLE, ARMING, SPINUP, FLIGHT, DESCEND, FAULT.
  task automatic model_step(input bit t, g, r, l, fc, input int thr, input bit rs);
    if (!rs) begin
      m_st = 0; m_duty = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      m_duty = 0; m_cnt = 0;
      if (r && g) m_st = 1;
    end else if (m_st == 5) begin
      m_duty = 0;
      if (fc && !r) m_st = 0;
    end else if (!g) begin
      m_st = 5; m_duty = 0; m_cnt = 0;
    end else if (m_st == 1) begin
      if (!r || l) begin
        m_st = 0; m_cnt = 0;
      end else if (t) begin
        m_cnt++;
        if (m_cnt == ARM_TICKS) begin
          m_st = 2; m_duty = MIN_D; m_cnt = 0;
        end
      end
    end else if (m_st == 4) begin
      if (m_duty == 0) m_st = 0;
      else if (t) m_duty = (m_duty > STEP) ? m_duty - STEP : 0;
    end else if (!r || l) begin
      m_st = 4;
    end else if (m_st == 2) begin
      if (m_duty == HOVER) m_st = 3;
      else if (t) m_duty = (m_duty + STEP > HOVER) ? HOVER : m_duty + STEP;
    end else begin
      m_duty = (thr < MIN_D) ? MIN_D : ((thr > MAX_D) ? MAX_D : thr);
    end
  endtask

  task automatic cyc(input bit t, g, r, l, fc, input logic [7:0] thr, input bit rs);
    @(negedge clk);
    reset = rs; tick = t; gyrocheck = g; reciverenable = r;
    land_req = l; fault_clr = fc; throttle_cmd = thr;
    model_step(t, g, r, l, fc, int'(thr), rs);
    sb_q.push_back(mk(m_st, m_duty));
  endtask

  // Monitor: every clock the DUT presents a new registered output to check.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        compare("scoreboard", e);
      end
    end
  end

  initial begin
    bit l_r, r_r;
    #1 reset = 1'b0;
    #2 compare("reset_state", mk(0, 0));
    cyc(0, 1, 1, 0, 0, 8'd0, 0);
    cyc(0, 1, 1, 0, 0, 8'd0, 1);
    repeat (4) cyc(1, 1, 1, 0, 0, 8'd0, 1);
    repeat (6) cyc(1, 1, 1, 0, 0, 8'd0, 1);
    cyc(0, 1, 1, 0, 0, 8'd0, 1);
    cyc(0, 1, 1, 0, 0, 8'd10, 1);
    cyc(0, 1, 1, 0, 0, 8'd250, 1);
    cyc(0, 1, 1, 0, 0, 8'd100, 1);
    cyc(1, 1, 1, 0, 0, 8'd40, 1);
    cyc(0, 1, 1, 1, 0, 8'd40, 1);
    repeat (3) cyc(1, 1, 1, 1, 0, 8'd0, 1);
    cyc(0, 1, 1, 1, 0, 8'd0, 1);
    cyc(0, 1, 1, 0, 0, 8'd0, 1);
    repeat (2) cyc(1, 1, 1, 0, 0, 8'd0, 1);
    cyc(0, 1, 0, 0, 0, 8'd0, 1);
    cyc(0, 1, 1, 0, 0, 8'd0, 1);
    repeat (3) cyc(1, 1, 1, 0, 0, 8'd0, 1);
    cyc(0, 1, 1, 0, 0, 8'd0, 1);
    cyc(1, 1, 1, 0, 0, 8'd0, 1);
    repeat (2) cyc(1, 1, 1, 0, 0, 8'd0, 1);
    cyc(1, 0, 0, 0, 0, 8'd0, 1);
    cyc(0, 1, 1, 0, 1, 8'd0, 1);
    cyc(0, 1, 0, 0, 1, 8'd0, 1);
    cyc(0, 1, 1, 0, 0, 8'd0, 1);
    repeat (10) cyc(1, 1, 1, 0, 0, 8'd0, 1);
    cyc(0, 1, 1, 0, 0, 8'd0, 1);
    cyc(0, 1, 1, 0, 0, 8'd200, 1);
    cyc(0, 1, 1, 0, 0, 8'd200, 1);
    // Asynchronous reset in the middle of a clock phase while flying.
    @(negedge clk);
    #2 reset = 1'b0;
    #1 compare("async_reset", mk(0, 0));
    model_step(0, 1, 1, 0, 0, 200, 0);
    sb_q.push_back(mk(m_st, m_duty));
    cyc(0, 1, 1, 0, 0, 8'd0, 0);
    l_r = 1'b0; r_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) l_r = ~l_r;
      if ($urandom_range(0, 39) == 0) r_r = ~r_r;
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 79) != 0, r_r, l_r,
          $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 499) != 0);
    end
    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
